// File: rtl/dec_display_fmt_if.sv
// Bus between the decimal display formatter and its user: conversion request,
// captured operands, status and the eight seven-segment digit fields.
interface dec_display_fmt_if #(parameter int W = 16);
  logic         start;
  logic [W-1:0] value;
  logic         sgnd;
  logic         dp_en;
  logic [2:0]   dp_pos;
  logic         busy;
  logic         done;
  logic [6:0]   d7, d6, d5, d4, d3, d2, d1, d0;

  modport master (
    output start, value, sgnd, dp_en, dp_pos,
    input  busy, done, d7, d6, d5, d4, d3, d2, d1, d0
  );

  modport slave (
    input  start, value, sgnd, dp_en, dp_pos,
    output busy, done, d7, d6, d5, d4, d3, d2, d1, d0
  );
endinterface

// File: rtl/dec_display_fmt.sv
// Binary (signed or unsigned) to decimal converter producing blanked, signed
// seven-segment digit fields using iterative double dabble.
//
// state | meaning
// IDLE  | waiting for start, digit fields held
// LOAD  | derive sign and magnitude from captured value, clear BCD
// SHIFT | one add-3/shift iteration per cycle, W cycles
// FMT   | build and register digit fields, pulse done
module dec_display_fmt #(
  parameter int W = 16
) (
  input logic             clk,
  input logic             rst,
  dec_display_fmt_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FMT} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  val_q;
  logic [W-1:0]  mag;
  logic          sgnd_q;
  logic          dp_en_q;
  logic [2:0]    dp_pos_q;
  logic          neg;
  logic [31:0]   bcd;
  logic [31:0]   bcd_adj;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic [6:0]    fld_q [8];
  logic [6:0]    fld   [8];
  logic [2:0]    msd;
  logic [2:0]    lo_keep;
  logic [2:0]    top;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = FMT;
      FMT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  // Digits above the kept range blank; the dash sits just left of the top
  // digit and falls off naturally when the top digit is already index 7.
  always_comb begin
    msd = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    lo_keep = dp_en_q ? dp_pos_q : 3'd0;
    top     = (msd > lo_keep) ? msd : lo_keep;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) <= top)
        fld[i] = {1'b0, dp_en_q && (dp_pos_q == 3'(i)), 1'b0, bcd[4*i +: 4]};
      else if (neg && (i == int'(top) + 1))
        fld[i] = 7'h10;
      else
        fld[i] = 7'h40;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q    <= '0;
      sgnd_q   <= 1'b0;
      dp_en_q  <= 1'b0;
      dp_pos_q <= '0;
      neg      <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) fld_q[i] <= 7'h40;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            val_q    <= bus.value;
            sgnd_q   <= bus.sgnd;
            dp_en_q  <= bus.dp_en;
            dp_pos_q <= bus.dp_pos;
          end
        end
        LOAD: begin
          neg <= sgnd_q & val_q[W-1];
          // -2^(W-1) negates to itself, which read unsigned is the right magnitude
          mag <= (sgnd_q & val_q[W-1]) ? (~val_q + W'(1)) : val_q;
          bcd <= '0;
          cnt <= CW'(W - 1);
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[30:0], mag, 1'b0};
          cnt        <= cnt - 1'b1;
        end
        FMT: begin
          for (int i = 0; i < 8; i++) fld_q[i] <= fld[i];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.d0   = fld_q[0];
  assign bus.d1   = fld_q[1];
  assign bus.d2   = fld_q[2];
  assign bus.d3   = fld_q[3];
  assign bus.d4   = fld_q[4];
  assign bus.d5   = fld_q[5];
  assign bus.d6   = fld_q[6];
  assign bus.d7   = fld_q[7];
endmodule

// File: tb/tb_dec_display_fmt.sv
// Self-checking bench for dec_display_fmt (W=16): directed and random values
// compared against a decimal-arithmetic model of the display rules.
module tb_dec_display_fmt;
  localparam int W = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dec_display_fmt_if #(.W(W)) bus ();

  dec_display_fmt #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] fields();
    return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  // Expected display built from decimal digits of the magnitude.
  function automatic logic [55:0] model(input int unsigned v, input bit s,
                                        input bit e, input int p);
    logic [55:0] r;
    int unsigned m;
    bit          neg;
    int          dig [8];
    int          msd, top;
    logic [6:0]  f;
    neg = s && (v >= 32768);
    m   = neg ? (65536 - v) : v;
    for (int i = 0; i < 8; i++) begin
      dig[i] = int'(m % 10);
      m      = m / 10;
    end
    msd = 0;
    for (int i = 0; i < 8; i++) if (dig[i] != 0) msd = i;
    top = (e && p > msd) ? p : msd;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i <= top)                f = {1'b0, e && (i == p), 1'b0, 4'(dig[i])};
      else if (neg && i == top + 1) f = 7'h10;
      else                          f = 7'h40;
      r[7*i +: 7] = f;
    end
    return r;
  endfunction

  task automatic issue(input int unsigned v, input bit s, input bit e, input int p);
    @(negedge clk);
    bus.value  = 16'(v);
    bus.sgnd   = s;
    bus.dp_en  = e;
    bus.dp_pos = 3'(p);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_load", bus.busy, 1'b1);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.value  = 16'($urandom);
    bus.sgnd   = 1'($urandom);
    bus.dp_en  = 1'($urandom);
    bus.dp_pos = 3'($urandom);
  endtask

  task automatic wait_done(input int inject, input logic [55:0] hold, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.done && inject != 0 && n == inject) begin
        chk("hold_mid", fields(), hold);
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 16'($urandom);
      end else if (!bus.done && inject != 0 && n == inject + 1) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end while (!bus.done && n < 60);
    chk("busy_at_done", bus.busy, 1'b0);
  endtask

  task automatic run(input int unsigned v, input bit s, input bit e, input int p,
                     input string tag);
    int n;
    issue(v, s, e, p);
    wait_done(0, '0, n);
    chk({tag, "_lat"}, n, W + 2);
    chk(tag, fields(), model(v, s, e, p));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int          n, cnt;
    int unsigned v, v2;
    bit          s, e, s2, e2;
    int          p, p2;
    logic [55:0] prev;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.value  = '0;
    bus.sgnd   = 1'b0;
    bus.dp_en  = 1'b0;
    bus.dp_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fields", fields(), {8{7'h40}});
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    run(1234,     0, 0, 0, "u1234");
    run(16'h8000, 1, 0, 0, "smin");
    run(5,        0, 1, 2, "dp2");
    run(0,        1, 0, 0, "zero_s");
    run(16'hFFFF, 0, 0, 0, "umax");
    run(16'hFFFF, 1, 1, 7, "neg_dp7");
    run(16'hFFF6, 1, 1, 5, "neg_dp5");
    run(0,        0, 1, 7, "zero_dp7");

    for (int k = 0; k < 30; k++) begin
      run($urandom_range(0, 65535), 1'($urandom), 1'($urandom),
          $urandom_range(0, 7), "rand");
    end

    // start during SHIFT ignored, then start on the done cycle accepted
    prev = fields();
    v = 43210; s = 0; e = 1; p = 3;
    issue(v, s, e, p);
    wait_done(5, prev, n);
    chk("ign_lat", n, W + 2);
    chk("ign_fields", fields(), model(v, s, e, p));
    v2 = 16'hC000; s2 = 1; e2 = 0; p2 = 0;
    issue(v2, s2, e2, p2);
    wait_done(0, '0, n);
    chk("b2b_lat", n, W + 2);
    chk("b2b_fields", fields(), model(v2, s2, e2, p2));

    // reset in the middle of SHIFT aborts and blanks
    issue(999, 0, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_fields", fields(), {8{7'h40}});
    chk("abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_hold", fields(), {8{7'h40}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
